// File: rtl/audio_rx_pkg.sv
// -----------------------------------------------------------------------------
// audio_rx_pkg
// Shared constants and types for the I2S-style audio receiver.
//   AUDIO_W  : width of the MSB-aligned sample outputs
//   CNT_W    : width of the per-channel bit counter (must hold 0..32)
//   state_e  : receiver state (ALIGN until first ws rise, then LEFT/RIGHT)
// -----------------------------------------------------------------------------
package audio_rx_pkg;

    localparam int AUDIO_W = 32;
    localparam int CNT_W   = 6;

    typedef enum logic [1:0] {
        ST_ALIGN = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_e;

endpackage

// File: rtl/audio_rx_edge_sync.sv
// -----------------------------------------------------------------------------
// audio_rx_edge_sync
// Two-flop synchronizer for an asynchronous codec pin plus one history flop,
// producing the synchronized level and single-cycle rise/fall strobes.
// Ports:
//   clk, rst  : system clock, asynchronous active-high reset
//   sig_i     : asynchronous input pin
//   level_o   : synchronized level (second sync stage)
//   rise_o    : 1 for one clk when the synchronized level goes 0->1
//   fall_o    : 1 for one clk when the synchronized level goes 1->0
// -----------------------------------------------------------------------------
module audio_rx_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    // [0] = first sync stage, [1] = second sync stage, [2] = history
    logic [2:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], sig_i};
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~sync_q[2];
    assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/audio_rx.sv
// -----------------------------------------------------------------------------
// audio_rx
// I2S-style audio receiver. Oversamples bit clock, word clock and serial data
// in the clk domain, assembles one left/right pair per frame (ws_lrc=1 left,
// ws_lrc=0 right, MSB first, sampled on bclk rise) and presents it with a
// one-cycle data_valid pulse. frame_err pulses when a channel ends short.
// Parameters:
//   DATA_W      : bits captured per channel (1..32), MSB-aligned into 32 bits
// Build option:
//   AUDIO_RX_DELAY1_EN : when defined, Philips I2S timing - the first bclk
//                        rise after each word-clock edge is skipped. When not
//                        defined, left-justified timing (first rise is MSB).
// Ports:
//   clk, rst    : system clock (>= 4x bclk), asynchronous active-high reset
//   sck_bclk    : codec bit clock (async)
//   ws_lrc      : codec word clock (async)
//   sdata       : codec ADC serial data (async)
//   left_data   : last complete left sample
//   right_data  : last complete right sample
//   data_valid  : 1-cycle pulse, new pair on left_data/right_data
//   frame_err   : 1-cycle pulse, a channel ended with fewer than DATA_W bits
// -----------------------------------------------------------------------------
module audio_rx
    import audio_rx_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sck_bclk,
    input  logic               ws_lrc,
    input  logic               sdata,
    output logic [AUDIO_W-1:0] left_data,
    output logic [AUDIO_W-1:0] right_data,
    output logic               data_valid,
    output logic               frame_err
);

`ifdef AUDIO_RX_DELAY1_EN
    localparam bit SKIP_FIRST = 1'b1;
`else
    localparam bit SKIP_FIRST = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Input synchronization
    // ------------------------------------------------------------------
    logic bclk_level, bclk_rise, bclk_fall;
    logic ws_level, ws_rise, ws_fall;
    logic [1:0] sdata_sync_q;
    logic sdata_s;

    audio_rx_edge_sync u_bclk_sync (
        .clk     (clk),
        .rst     (rst),
        .sig_i   (sck_bclk),
        .level_o (bclk_level),
        .rise_o  (bclk_rise),
        .fall_o  (bclk_fall)
    );

    audio_rx_edge_sync u_ws_sync (
        .clk     (clk),
        .rst     (rst),
        .sig_i   (ws_lrc),
        .level_o (ws_level),
        .rise_o  (ws_rise),
        .fall_o  (ws_fall)
    );

    // Same two-stage delay as the edge detectors so data lines up with bclk_rise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdata_sync_q <= '0;
        end else begin
            sdata_sync_q <= {sdata_sync_q[0], sdata};
        end
    end
    assign sdata_s = sdata_sync_q[1];

    logic unused_sync;
    assign unused_sync = ^{bclk_level, bclk_fall, ws_level};

    // ------------------------------------------------------------------
    // Capture datapath
    // ------------------------------------------------------------------
    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_base;
    logic               skip_q, skip_d, skip_base;
    logic [AUDIO_W-1:0] left_sr_q, left_sr_d;
    logic [AUDIO_W-1:0] right_sr_q, right_sr_d;
    logic [AUDIO_W-1:0] left_hold_q;
    logic               enter_left, enter_right, enter, in_frame;
    logic               to_left_chan, take, short_word, pair_done;
    logic [4:0]         bit_idx;

    always_comb begin
        enter_left   = ws_rise && (state_q != ST_LEFT);
        enter_right  = ws_fall && (state_q == ST_LEFT);
        enter        = enter_left || enter_right;
        pair_done    = enter_left && (state_q == ST_RIGHT);
        in_frame     = enter || (state_q != ST_ALIGN);
        to_left_chan = enter_left || (!enter_right && (state_q == ST_LEFT));
        short_word   = cnt_q < CNT_W'(DATA_W);

        // A word-clock edge is applied before any bit sampled in the same
        // cycle, so that bit lands as bit 0 of the newly entered channel.
        cnt_base  = enter ? '0 : cnt_q;
        skip_base = SKIP_FIRST && (enter || skip_q);
        take      = bclk_rise && in_frame && !skip_base
                    && (cnt_base < CNT_W'(DATA_W));
        bit_idx   = 5'(AUDIO_W - 1 - int'(cnt_base));

        left_sr_d  = enter_left  ? '0 : left_sr_q;
        right_sr_d = enter_right ? '0 : right_sr_q;
        if (take) begin
            if (to_left_chan) begin
                left_sr_d[bit_idx] = sdata_s;
            end else begin
                right_sr_d[bit_idx] = sdata_s;
            end
        end

        cnt_d  = cnt_base;
        skip_d = skip_base;
        if (bclk_rise && in_frame) begin
            if (skip_base) begin
                skip_d = 1'b0;
            end else if (take) begin
                cnt_d = cnt_base + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ALIGN;
            cnt_q       <= '0;
            skip_q      <= 1'b0;
            left_sr_q   <= '0;
            right_sr_q  <= '0;
            left_hold_q <= '0;
            left_data   <= '0;
            right_data  <= '0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            if (enter_left) begin
                state_q <= ST_LEFT;
            end else if (enter_right) begin
                state_q <= ST_RIGHT;
            end
            cnt_q      <= cnt_d;
            skip_q     <= skip_d;
            left_sr_q  <= left_sr_d;
            right_sr_q <= right_sr_d;

            // Left word is parked until the matching right word completes
            if (enter_right) begin
                left_hold_q <= left_sr_q;
            end
            if (pair_done) begin
                left_data  <= left_hold_q;
                right_data <= right_sr_q;
            end
            data_valid <= pair_done;
            frame_err  <= (enter_right || pair_done) && short_word;
        end
    end

endmodule
